// File: rtl/edge_evt_pkg.sv
// ---------------------------------------------------------------------------
// edge_evt_pkg
// Shared types for the edge event scheduler.
//   ev_kind_t     : kind of a queued/offered event (rise or 010 pulse)
//   sched_state_t : output scheduler state (idle / offering an event)
// ---------------------------------------------------------------------------
package edge_evt_pkg;

    typedef enum logic {
        EV_RISE  = 1'b0,
        EV_PULSE = 1'b1
    } ev_kind_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker. The search starts at i_ptr+1 (mod N)
// and returns the first requesting index found.
// Ports:
//   i_req       in  N     request per line
//   i_ptr       in  ID_W  last granted index
//   o_gnt_valid out 1     at least one request present
//   o_gnt_id    out ID_W  granted index (0 when o_gnt_valid=0)
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic                 o_gnt_valid,
    output logic [$clog2(N)-1:0] o_gnt_id
);
    localparam int ID_W = $clog2(N);

    logic [ID_W-1:0] w_idx;

    // Walk from the farthest candidate to the nearest one; the last hit
    // written is the nearest to ptr+1, which is the round-robin winner.
    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_id    = '0;
        w_idx       = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = ID_W'((int'(i_ptr) + k) % N);
            if (i_req[w_idx]) begin
                o_gnt_valid = 1'b1;
                o_gnt_id    = w_idx;
            end
        end
    end

endmodule

// File: rtl/edge_event_scheduler.sv
// ---------------------------------------------------------------------------
// edge_event_scheduler
// Detects rising edges and one-cycle (010) pulses on N_CH sampled lines,
// keeps one pending event per line and offers them round-robin on a single
// valid/ready output.
// Ports:
//   clk          in  1     clock, posedge
//   rst          in  1     asynchronous active-high reset
//   a            in  N_CH  sampled lines
//   en           in  N_CH  per-line enable (detection and grant eligibility)
//   out_valid    out 1     event offered
//   out_ready    in  1     consumer accepts
//   out_id       out ID_W  line index of offered event
//   out_kind     out 1     0 = EV_RISE, 1 = EV_PULSE
//   overflow     out N_CH  sticky per-line dropped-event flag
//   clr_overflow in  1     clears overflow (a drop on the same edge wins)
// Handshake: an event moves when out_valid & out_ready are both high at a
// posedge; while out_valid=1 and no transfer, out_id/out_kind are stable.
// ---------------------------------------------------------------------------
module edge_event_scheduler
    import edge_evt_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         a,
    input  logic [N_CH-1:0]         en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(N_CH)-1:0] out_id,
    output logic                    out_kind,
    output logic [N_CH-1:0]         overflow,
    input  logic                    clr_overflow
);
    localparam int ID_W = $clog2(N_CH);

    logic [N_CH-1:0] r_a;
    logic [N_CH-1:0] r_aa;
    logic [N_CH-1:0] r_pend;
    logic [N_CH-1:0] r_kind;
    logic [N_CH-1:0] r_ovf;
    logic            r_valid;
    logic [ID_W-1:0] r_id;
    logic            r_okind;
    logic [ID_W-1:0] r_ptr;
    sched_state_t    r_state;

    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_pulse;
    logic [N_CH-1:0] w_elig;
    logic [N_CH-1:0] w_load_vec;
    logic [N_CH-1:0] w_pend_nxt;
    logic [N_CH-1:0] w_kind_nxt;
    logic [N_CH-1:0] w_drop;
    logic            w_gnt_valid;
    logic [ID_W-1:0] w_gnt_id;
    logic            w_gnt_kind;
    logic            w_load;

    assign w_rise  = a & ~r_a & en;
    assign w_pulse = ~a & r_a & ~r_aa & en;
    assign w_elig  = r_pend & en;

    rr_picker #(.N(N_CH)) u_picker (
        .i_req       (w_elig),
        .i_ptr       (r_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    // A new event is loaded from IDLE, or in OFFER only on a transfer.
    assign w_load = w_gnt_valid && ((r_state == S_IDLE) || out_ready);

    always_comb begin
        w_load_vec = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_load_vec[i] = w_load && (w_gnt_id == ID_W'(i));
        end
    end

    assign w_gnt_kind = |(r_kind & w_load_vec);

    // Pending bookkeeping. Clearing the loaded line first lets a same-edge
    // detection re-arm it without counting as an overflow.
    always_comb begin
        w_pend_nxt = r_pend;
        w_kind_nxt = r_kind;
        w_drop     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_load_vec[i]) begin
                w_pend_nxt[i] = 1'b0;
            end
            if (w_rise[i]) begin
                if (w_pend_nxt[i]) begin
                    w_drop[i] = 1'b1;
                end else begin
                    w_pend_nxt[i] = 1'b1;
                    w_kind_nxt[i] = EV_RISE;
                end
            end else if (w_pulse[i]) begin
                // Either upgrades a still-pending rise or creates a new event.
                w_pend_nxt[i] = 1'b1;
                w_kind_nxt[i] = EV_PULSE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_aa    <= '0;
            r_pend  <= '0;
            r_kind  <= '0;
            r_ovf   <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_okind <= 1'b0;
            r_ptr   <= ID_W'(N_CH - 1);
            r_state <= S_IDLE;
        end else begin
            r_a    <= a;
            r_aa   <= r_a;
            r_pend <= w_pend_nxt;
            r_kind <= w_kind_nxt;
            r_ovf  <= (clr_overflow ? '0 : r_ovf) | w_drop;
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_valid <= 1'b1;
                        r_id    <= w_gnt_id;
                        r_okind <= w_gnt_kind;
                        r_ptr   <= w_gnt_id;
                        r_state <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (out_ready) begin
                        if (w_load) begin
                            r_id    <= w_gnt_id;
                            r_okind <= w_gnt_kind;
                            r_ptr   <= w_gnt_id;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_id    = r_id;
    assign out_kind  = r_okind;
    assign overflow  = r_ovf;

endmodule
